// File: rtl/byte_link_pkg.sv
// Shared definitions for the byte-serial link master.
// Holds the mode encodings, byte-count constants, the FSM state type and
// small helpers that turn a request mode/length into link byte counts.
package byte_link_pkg;

  localparam logic [1:0] MODE_AES_ENC = 2'd0;
  localparam logic [1:0] MODE_AES_DEC = 2'd1;
  localparam logic [1:0] MODE_SHA3    = 2'd2;  // 3 is also SHA3-256

  localparam logic [5:0] AES_TX_BYTES  = 6'd32;  // plaintext/cipher + key
  localparam logic [5:0] AES_RX_BYTES  = 6'd16;
  localparam logic [5:0] SHA_RX_BYTES  = 6'd32;
  localparam logic [5:0] SHA_MAX_BYTES = 6'd32;  // longest SHA message accepted

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } state_t;

  function automatic logic is_aes(input logic [1:0] mode);
    return (mode == MODE_AES_ENC) || (mode == MODE_AES_DEC);
  endfunction

  function automatic logic is_sha(input logic [1:0] mode);
    return mode >= MODE_SHA3;
  endfunction

  // Bytes the crypto top returns for a given mode.
  function automatic logic [5:0] rx_bytes(input logic [1:0] mode);
    return is_aes(mode) ? AES_RX_BYTES : SHA_RX_BYTES;
  endfunction

  // Bytes pushed onto the link; AES always sends a full block plus key.
  function automatic logic [5:0] tx_bytes(input logic [1:0] mode, input logic [5:0] len);
    return is_aes(mode) ? AES_TX_BYTES : len;
  endfunction

endpackage

// File: rtl/byte_link_master_if.sv
// Signal bundle between the host, the link master and the crypto top.
//
// Handshake rules (request and response channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The source holds valid and its payload stable until that edge; ready may
//   change freely and never depends combinationally on valid.
//
// Groups:
//   req_*  host -> master request (valid/ready, mode, len, 256-bit data)
//   rsp_*  master -> host response (valid/ready, 256-bit data, err)
//   dut_*  master <-> crypto top byte link (data/start/mode out, odata/ovalid in)
// Modports: master = the link master, slave = host / crypto-top side.
interface byte_link_master_if;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_mode;
  logic [5:0]   req_len;
  logic [255:0] req_data;

  logic [7:0]   dut_data;
  logic         dut_start;
  logic [1:0]   dut_mode;
  logic [7:0]   dut_odata;
  logic         dut_ovalid;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_data;
  logic         rsp_err;

  modport master (
    input  req_valid, req_mode, req_len, req_data,
    input  dut_odata, dut_ovalid,
    input  rsp_ready,
    output req_ready,
    output dut_data, dut_start, dut_mode,
    output rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_mode, req_len, req_data,
    output dut_odata, dut_ovalid,
    output rsp_ready,
    input  req_ready,
    input  dut_data, dut_start, dut_mode,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/byte_link_deser.sv
// 256-bit byte collector: the n-th written byte lands at [8n+7:8n].
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         zero the word and the count (wins over we)
//   we          write din at the current count and advance it
//   din         incoming byte
//   data        collected word
//   count       bytes collected so far (0..32)
module byte_link_deser (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic [7:0]   din,
  output logic [255:0] data,
  output logic [5:0]   count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clr) begin
      data  <= '0;
      count <= '0;
    end else if (we && !count[5]) begin
      // count[5] set means the word is full; further bytes are dropped.
      data[{count[4:0], 3'b000} +: 8] <= din;
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/byte_link_master.sv
// Host-side initiator for the crypto top's byte-serial link.
// Takes one parallel request (mode + up to 32 bytes), streams it onto the
// link with dut_start high, waits for the o_valid burst and returns it as a
// 256-bit response (byte k at [8k+7:8k]).
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (shared with crypto top)
//   bus         byte_link_master_if.master: req_*, rsp_*, dut_* groups
//   state_dbg   current FSM state
// Parameters:
//   TIMEOUT_CYC idle WAIT cycles before error (timeout build only)
//   TCW         timeout counter width, must hold TIMEOUT_CYC
// Build option:
//   BYTE_LINK_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT_CYC
//                         cycles without dut_ovalid and reports rsp_err.
module byte_link_master
  import byte_link_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int TCW         = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  byte_link_master_if.master bus,
  output state_t             state_dbg
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TCW)) begin : g_bad_cfg
    $error("byte_link_master: TCW too narrow for TIMEOUT_CYC");
  end

  state_t       state_q, state_d;
  logic         req_ready_q;
  logic [7:0]   dut_data_q, dut_data_d;
  logic         dut_start_q, dut_start_d;
  logic [1:0]   dut_mode_q, dut_mode_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_err_q, rsp_err_d;
  logic [255:0] tx_shift_q, tx_shift_d;  // bytes still to send, next at top
  logic [5:0]   tx_left_q, tx_left_d;    // bytes after the one on dut_data
  logic [5:0]   rx_exp_q, rx_exp_d;

  logic         deser_clr, deser_we;
  logic [255:0] rx_data;
  logic [5:0]   rx_count;
  logic         accept, len_bad, tmo_hit;

  assign accept  = bus.req_valid && req_ready_q;
  assign len_bad = is_sha(bus.req_mode) &&
                   ((bus.req_len == 6'd0) || (bus.req_len > SHA_MAX_BYTES));

`ifdef BYTE_LINK_TIMEOUT_EN
  logic [TCW-1:0] tmo_cnt;

  // Held at zero outside WAIT, so every WAIT visit starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt <= '0;
    else if (state_q != ST_WAIT) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TCW'(1);
  end

  assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt == TCW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  byte_link_deser u_deser (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (deser_clr),
    .we    (deser_we),
    .din   (bus.dut_odata),
    .data  (rx_data),
    .count (rx_count)
  );

  always_comb begin
    state_d     = state_q;
    dut_data_d  = 8'h00;
    dut_start_d = 1'b0;
    dut_mode_d  = dut_mode_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    tx_shift_d  = tx_shift_q;
    tx_left_d   = tx_left_q;
    rx_exp_d    = rx_exp_q;
    deser_clr   = 1'b0;
    deser_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dut_mode_d = bus.req_mode;
          rx_exp_d   = rx_bytes(bus.req_mode);
          rsp_err_d  = 1'b0;
          deser_clr  = 1'b1;
          if (len_bad) begin
            rsp_err_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            // Byte 0 goes out on the accept edge itself.
            dut_start_d = 1'b1;
            dut_data_d  = bus.req_data[255:248];
            tx_shift_d  = {bus.req_data[247:0], 8'h00};
            tx_left_d   = tx_bytes(bus.req_mode, bus.req_len) - 6'd1;
            state_d     = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (tx_left_q == 6'd0) begin
          state_d = ST_WAIT;
        end else begin
          dut_start_d = 1'b1;
          dut_data_d  = tx_shift_q[255:248];
          tx_shift_d  = {tx_shift_q[247:0], 8'h00};
          tx_left_d   = tx_left_q - 6'd1;
        end
      end

      ST_WAIT: begin
        if (bus.dut_ovalid) begin
          deser_we = 1'b1;
          state_d  = ST_RECV;
        end else if (tmo_hit) begin
          rsp_err_d = 1'b1;
          deser_clr = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_RECV: begin
        if (bus.dut_ovalid) begin
          deser_we = 1'b1;
          if (rx_count + 6'd1 == rx_exp_q) state_d = ST_DONE;
        end else begin
          rsp_err_d = 1'b1;  // burst ended early
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // First DONE cycle raises rsp_valid; payload is already settled.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          dut_mode_d  = 2'd0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      dut_data_q  <= 8'h00;
      dut_start_q <= 1'b0;
      dut_mode_q  <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      tx_shift_q  <= '0;
      tx_left_q   <= '0;
      rx_exp_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      dut_data_q  <= dut_data_d;
      dut_start_q <= dut_start_d;
      dut_mode_q  <= dut_mode_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      tx_shift_q  <= tx_shift_d;
      tx_left_q   <= tx_left_d;
      rx_exp_q    <= rx_exp_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.dut_data  = dut_data_q;
  assign bus.dut_start = dut_start_q;
  assign bus.dut_mode  = dut_mode_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rx_data;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_byte_link_master.sv
module tb_byte_link_master;
  import byte_link_pkg::*;

`ifdef BYTE_LINK_TIMEOUT_EN
  localparam int TMO_CYC = 20;
`else
  localparam int TMO_CYC = 1023;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_link_master_if bus ();
  state_t state_dbg;

  byte_link_master #(.TIMEOUT_CYC(TMO_CYC), .TCW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int rsp_cnt  = 0;
  bit ignore_link = 1'b0;

  logic [7:0]   exp_tx_q[$];     // bytes expected on dut_data
  logic [7:0]   exp_burst_q[$];  // {mode, burst length}
  logic [258:0] exp_rsp_q[$];    // {mode, err, data}

  function automatic void check(input string name, input logic [259:0] act, input logic [259:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endfunction

  function automatic void fail_evt(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event/expired wait, want none", name);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic void check_all_zero(input string tag);
    check({tag, "_ctrl"}, {bus.req_ready, bus.dut_start, bus.dut_data, bus.dut_mode,
                           bus.rsp_valid, bus.rsp_err}, '0);
    check({tag, "_rsp_data"}, bus.rsp_data, '0);
  endfunction

  // ---------------- link monitor ----------------
  int         burst_n    = 0;
  logic       prev_start = 1'b0;
  logic [7:0] tx_e, burst_e;

  always @(negedge clk) begin
    if (!rst_n || ignore_link) begin
      prev_start = 1'b0;
      burst_n    = 0;
    end else begin
      if (bus.dut_start) begin
        if (exp_tx_q.size() == 0 || exp_burst_q.size() == 0) begin
          fail_evt("unexpected_dut_start");
        end else begin
          tx_e = exp_tx_q.pop_front();
          check("tx_byte", bus.dut_data, tx_e);
          check("tx_mode", bus.dut_mode, exp_burst_q[0][7:6]);
        end
        burst_n++;
      end else if (prev_start) begin
        check("tx_idle_data", bus.dut_data, 8'h00);
        if (exp_burst_q.size() == 0) begin
          fail_evt("unexpected_burst_end");
        end else begin
          burst_e = exp_burst_q.pop_front();
          check("burst_len", burst_n, burst_e[5:0]);
        end
        burst_n = 0;
      end
      prev_start = bus.dut_start;
    end
  end

  // ---------------- response monitor ----------------
  logic         prev_hold = 1'b0;
  logic [256:0] prev_rsp;
  logic [258:0] rsp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("rsp_hold_valid", bus.rsp_valid, 1'b1);
        check("rsp_hold_payload", {bus.rsp_err, bus.rsp_data}, prev_rsp);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          fail_evt("unexpected_rsp");
        end else begin
          rsp_e = exp_rsp_q.pop_front();
          check("rsp_data", bus.rsp_data, rsp_e[255:0]);
          check("rsp_err", bus.rsp_err, rsp_e[256]);
          check("rsp_mode", bus.dut_mode, rsp_e[258:257]);
        end
        rsp_cnt++;
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp  = {bus.rsp_err, bus.rsp_data};
    end
  end

  // ---------------- response backpressure ----------------
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver + responder ----------------
  // give = bytes the responder puts on dut_ovalid (0 = silent).
  task automatic run_txn(input logic [1:0] mode, input logic [5:0] len, input logic [255:0] data,
                         input logic [255:0] result, input int give, input int lat);
    logic         bad;
    int           n_tx, n_rx, got, t, rsp_before;
    logic [255:0] exp_d;

    // Reference model: what the link should carry and what comes back.
    bad  = (mode >= MODE_SHA3) && (len == 6'd0 || len > 6'd32);
    n_tx = (mode >= MODE_SHA3) ? int'(len) : 32;
    n_rx = (mode >= MODE_SHA3) ? 32 : 16;
    if (bad) begin
      exp_rsp_q.push_back({mode, 1'b1, 256'd0});
    end else begin
      for (int k = 0; k < n_tx; k++) exp_tx_q.push_back(data[255-8*k -: 8]);
      exp_burst_q.push_back({mode, 6'(n_tx)});
      got   = (give < n_rx) ? give : n_rx;
      exp_d = '0;
      for (int k = 0; k < got; k++) exp_d[8*k +: 8] = result[8*k +: 8];
      exp_rsp_q.push_back({mode, (give < n_rx), exp_d});
    end

    rsp_before = rsp_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_len   = len;
    bus.req_data  = data;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      fail_evt("req_ready_wait");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = rand256();
    @(negedge clk);
    check("start_after_accept", bus.dut_start, !bad);

    if (bad) begin
      check("bad_len_valid_c1", bus.rsp_valid, 1'b0);
      @(negedge clk);
      check("bad_len_valid_c2", bus.rsp_valid, 1'b1);
      check("bad_len_err_c2", bus.rsp_err, 1'b1);
    end else begin
      t = 0;
      while (bus.dut_start && t < 64) begin
        @(negedge clk);
        t++;
      end
      // This negedge is the first cycle spent in WAIT.
      if (give == 0) begin
        for (int c = 1; c <= TMO_CYC; c++) begin
          @(negedge clk);
          if (c == TMO_CYC - 1) check("tmo_err_early", bus.rsp_err, 1'b0);
          if (c == TMO_CYC)     check("tmo_err_at_limit", bus.rsp_err, 1'b1);
        end
      end else begin
        repeat (lat) @(posedge clk);
        for (int k = 0; k < give; k++) begin
          @(posedge clk);
          #1;
          bus.dut_ovalid = 1'b1;
          bus.dut_odata  = result[8*(k%32) +: 8];
        end
        @(posedge clk);
        #1;
        bus.dut_ovalid = 1'b0;
        bus.dut_odata  = 8'h00;
      end
    end

    t = 0;
    while (rsp_cnt == rsp_before && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (rsp_cnt == rsp_before) fail_evt("rsp_wait");
  endtask

  task automatic reset_mid_send();
    int t;
    ignore_link = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_mode  = MODE_AES_ENC;
    bus.req_len   = 6'd32;
    bus.req_data  = rand256();
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("send_before_reset", bus.dut_start, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_ready", bus.req_ready, 1'b1);
    check("post_reset_quiet", {bus.dut_start, bus.dut_mode, bus.rsp_valid, bus.rsp_err}, '0);
    check("post_reset_state", state_dbg, ST_IDLE);
    ignore_link = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] SHA_ABC = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;

  initial begin
    logic [1:0] mode;
    logic [5:0] len;
    int         r, n_rx, give;

    bus.req_valid  = 1'b0;
    bus.req_mode   = 2'd0;
    bus.req_len    = 6'd0;
    bus.req_data   = '0;
    bus.dut_odata  = 8'h00;
    bus.dut_ovalid = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", bus.req_ready, 1'b0);
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1'b1);

    // Directed known-answer cases.
    run_txn(MODE_AES_ENC, 6'd0, {AES_PT, AES_KEY}, {128'd0, AES_CT}, 16, 2);
    run_txn(MODE_AES_DEC, 6'd0, {AES_CT, AES_KEY}, {128'd0, AES_PT}, 16, 1);
    run_txn(MODE_SHA3, 6'd3, {24'h616263, 232'd0}, SHA_ABC, 32, 3);
    run_txn(MODE_SHA3, 6'd0, rand256(), rand256(), 32, 0);
    run_txn(MODE_SHA3, 6'd33, rand256(), rand256(), 32, 0);
    run_txn(MODE_AES_ENC, 6'd0, rand256(), rand256(), 10, 1);
    run_txn(2'd3, 6'd32, rand256(), rand256(), 34, 0);

    // Randomized traffic.
    for (int i = 0; i < 14; i++) begin
      mode = 2'($urandom_range(0, 3));
      r    = $urandom_range(0, 9);
      if (r == 0)      len = 6'($urandom_range(33, 63));
      else if (r == 1) len = 6'd0;
      else             len = 6'($urandom_range(1, 32));
      n_rx = (mode >= MODE_SHA3) ? 32 : 16;
      if ($urandom_range(0, 4) == 0) give = $urandom_range(1, n_rx - 1);
      else                           give = n_rx + $urandom_range(0, 2);
      run_txn(mode, len, rand256(), rand256(), give, $urandom_range(0, 3));
    end

    reset_mid_send();
    run_txn(MODE_AES_DEC, 6'd0, rand256(), rand256(), 16, 0);

`ifdef BYTE_LINK_TIMEOUT_EN
    run_txn(MODE_SHA3, 6'd5, rand256(), rand256(), 0, 0);
`endif

    repeat (5) @(negedge clk);
    check("queues_drained", exp_tx_q.size() + exp_burst_q.size() + exp_rsp_q.size(), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
